// File: rtl/regread_bypass_pkg.sv
// Shared constants and state encoding for the regread_bypass operand-fetch stage.
package regread_bypass_pkg;

    localparam int RB_AW   = 6;
    localparam int RB_XLEN = 32;
    localparam int RB_TAGW = 32;

    localparam logic [RB_AW-1:0] RB_X0_ADDR = 6'd0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READY = 2'd3
    } state_e;

endpackage

// File: rtl/regread_bypass_lane.sv
// One source-operand lane: write-port bypass covering BRAM read-during-write, plus x0 masking.
module regread_bypass_lane
    import regread_bypass_pkg::*;
#(
    parameter int AW   = RB_AW,
    parameter int XLEN = RB_XLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [AW-1:0]   rd_addr_i,
    input  logic [AW-1:0]   held_addr_i,
    input  logic            wb_we_i,
    input  logic [AW-1:0]   wb_wa_i,
    input  logic [XLEN-1:0] wb_wd_i,
    input  logic            wb_wg_i,
    input  logic [XLEN-1:0] rf_rd_i,
    input  logic            rf_rg_i,
    output logic [XLEN-1:0] op_o,
    output logic            g_o
);

    logic            byp_hit_q, byp_hit_d;
    logic [XLEN-1:0] byp_d_q,   byp_d_d;
    logic            byp_g_q,   byp_g_d;

    // Capture a write landing on the address the BRAM reads this cycle; its output will be stale.
    always_comb begin
        byp_hit_d = wb_we_i && (wb_wa_i == rd_addr_i) && (rd_addr_i != {AW{1'b0}});
        byp_d_d   = wb_wd_i;
        byp_g_d   = wb_wg_i;
    end

    // Bypass registers, aligned with the BRAM's one-cycle read latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byp_hit_q <= 1'b0;
            byp_d_q   <= {XLEN{1'b0}};
            byp_g_q   <= 1'b0;
        end else begin
            byp_hit_q <= byp_hit_d;
            byp_d_q   <= byp_d_d;
            byp_g_q   <= byp_g_d;
        end
    end

    // Effective operand: x0 is hard zero and never grubby, else bypass beats BRAM data.
    always_comb begin
        if (held_addr_i == {AW{1'b0}}) begin
            op_o = {XLEN{1'b0}};
            g_o  = 1'b0;
        end else if (byp_hit_q) begin
            op_o = byp_d_q;
            g_o  = byp_g_q;
        end else begin
            op_o = rf_rd_i;
            g_o  = rf_rg_i;
        end
    end

endmodule

// File: rtl/regread_bypass.sv
// Operand-fetch stage behind the 64x36 BRAM register set; holds each instruction until both
// operands are non-grubby. Optional WAIT-cycle counter enabled by REGREAD_STALL_CNT_EN.
module regread_bypass
    import regread_bypass_pkg::*;
#(
    parameter int AW   = RB_AW,
    parameter int XLEN = RB_XLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_ra1,
    input  logic [AW-1:0]   in_ra2,
    input  logic [31:0]     in_tag,
    output logic [AW-1:0]   rf_ra1,
    output logic [AW-1:0]   rf_ra2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic            rf_rg1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            rf_rg2,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    input  logic            wb_wg,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [31:0]     out_tag
`ifdef REGREAD_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    state_e        state_q, state_d;
    logic [AW-1:0] ra1_q, ra1_d;
    logic [AW-1:0] ra2_q, ra2_d;
    logic [31:0]   tag_q, tag_d;

    logic          in_fire, out_fire, accept, grubby;
    logic [XLEN-1:0] op1, op2;
    logic          g1, g2;

    regread_bypass_lane #(.AW(AW), .XLEN(XLEN)) u_lane1 (
        .clk(clk), .rstn(rstn), .rd_addr_i(rf_ra1), .held_addr_i(ra1_q),
        .wb_we_i(wb_we), .wb_wa_i(wb_wa), .wb_wd_i(wb_wd), .wb_wg_i(wb_wg),
        .rf_rd_i(rf_rd1), .rf_rg_i(rf_rg1), .op_o(op1), .g_o(g1)
    );

    regread_bypass_lane #(.AW(AW), .XLEN(XLEN)) u_lane2 (
        .clk(clk), .rstn(rstn), .rd_addr_i(rf_ra2), .held_addr_i(ra2_q),
        .wb_we_i(wb_we), .wb_wa_i(wb_wa), .wb_wd_i(wb_wd), .wb_wg_i(wb_wg),
        .rf_rd_i(rf_rd2), .rf_rg_i(rf_rg2), .op_o(op2), .g_o(g2)
    );

    // Handshakes; valid is withheld in READY if a fresh write just made an operand grubby.
    always_comb begin
        grubby    = g1 | g2;
        out_valid = (state_q == ST_READY) && !grubby;
        out_fire  = out_valid && out_ready;
        in_ready  = (state_q == ST_EMPTY) || out_fire;
        in_fire   = in_valid && in_ready;
        accept    = in_fire && !flush;
        rf_ra1    = in_fire ? in_ra1 : ra1_q;
        rf_ra2    = in_fire ? in_ra2 : ra2_q;
        out_op1   = op1;
        out_op2   = op2;
        out_tag   = tag_q;
        ra1_d     = accept ? in_ra1 : ra1_q;
        ra2_d     = accept ? in_ra2 : ra2_q;
        tag_d     = accept ? in_tag : tag_q;
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_FETCH;
                else        state_d = ST_EMPTY;
            end
            ST_FETCH, ST_WAIT: begin
                if (grubby) state_d = ST_WAIT;
                else        state_d = ST_READY;
            end
            ST_READY: begin
                if (out_fire)    state_d = accept ? ST_FETCH : ST_EMPTY;
                else if (grubby) state_d = ST_WAIT;
                else             state_d = ST_READY;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_d;
        end
    end

    // Held instruction and FSM state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
            ra1_q   <= {AW{1'b0}};
            ra2_q   <= {AW{1'b0}};
            tag_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            ra1_q   <= ra1_d;
            ra2_q   <= ra2_d;
            tag_q   <= tag_d;
        end
    end

`ifdef REGREAD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Free-running count of WAIT cycles, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= 32'd0;
        end else if (state_q == ST_WAIT) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regread_bypass.sv
// Self-checking bench for regread_bypass: BRAM model, transaction-level reference, directed + random.
module tb_regread_bypass;

    localparam int AW   = 6;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rstn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [AW-1:0]   in_ra1, in_ra2, rf_ra1, rf_ra2, wb_wa;
    logic [31:0]     in_tag, out_tag;
    logic [XLEN-1:0] rf_rd1 = '0, rf_rd2 = '0, wb_wd, out_op1, out_op2;
    logic            rf_rg1 = 1'b0, rf_rg2 = 1'b0, wb_we, wb_wg;
`ifdef REGREAD_STALL_CNT_EN
    logic [31:0]     stall_cnt;
`endif

    regread_bypass #(.AW(AW), .XLEN(XLEN)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ra1(in_ra1), .in_ra2(in_ra2), .in_tag(in_tag), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_rd1(rf_rd1), .rf_rg1(rf_rg1), .rf_rd2(rf_rd2), .rf_rg2(rf_rg2),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_wg(wb_wg),
        .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
        .out_tag(out_tag)
`ifdef REGREAD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // BRAM register set: registered read, old data on read-during-write.
    logic [XLEN-1:0] mem_d [64];
    logic            mem_g [64];
    always @(posedge clk) begin
        rf_rd1 <= mem_d[rf_ra1];
        rf_rg1 <= mem_g[rf_ra1];
        rf_rd2 <= mem_d[rf_ra2];
        rf_rg2 <= mem_g[rf_ra2];
        if (wb_we) begin
            mem_d[wb_wa] <= wb_wd;
            mem_g[wb_wa] <= wb_wg;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: architectural register file plus the one held instruction.
    logic [XLEN-1:0] arch_d [64];
    logic            arch_g [64];
    bit              m_held = 1'b0, m_cprev = 1'b0;
    int              m_age = 0;
    logic [AW-1:0]   m_ra1 = '0, m_ra2 = '0;
    logic [31:0]     m_tag = '0;
    logic [31:0]     m_stall = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit clean(input logic [AW-1:0] a);
        return (a == 6'd0) || !arch_g[a];
    endfunction

    function automatic logic [XLEN-1:0] aval(input logic [AW-1:0] a);
        return (a == 6'd0) ? 32'd0 : arch_d[a];
    endfunction

    // One clock: check outputs against the reference, then advance the reference.
    task automatic tick();
        bit ev, eir, cn, fire_in;
        #1;
        cn  = clean(m_ra1) && clean(m_ra2);
        ev  = m_held && (m_age >= 2) && cn && m_cprev;
        eir = !m_held || (ev && out_ready);
        fire_in = in_valid && eir;
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("in_ready",  {31'd0, in_ready},  {31'd0, eir});
        chk("rf_ra1", {26'd0, rf_ra1}, {26'd0, fire_in ? in_ra1 : m_ra1});
        chk("rf_ra2", {26'd0, rf_ra2}, {26'd0, fire_in ? in_ra2 : m_ra2});
        if (ev) begin
            chk("out_op1", out_op1, aval(m_ra1));
            chk("out_op2", out_op2, aval(m_ra2));
            chk("out_tag", out_tag, m_tag);
        end
`ifdef REGREAD_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        if (m_held && (m_age >= 2) && !m_cprev) m_stall = m_stall + 32'd1;
        m_cprev = cn;
        if (flush) m_held = 1'b0;
        else if (fire_in) begin
            m_held = 1'b1; m_age = 1; m_ra1 = in_ra1; m_ra2 = in_ra2; m_tag = in_tag;
        end else if (ev && out_ready) m_held = 1'b0;
        else if (m_held && m_age < 3) m_age++;
        if (wb_we) begin
            arch_d[wb_wa] = wb_wd;
            arch_g[wb_wa] = wb_wg;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; wb_we = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic issue(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic [31:0] t);
        in_valid = 1'b1; in_ra1 = a1; in_ra2 = a2; in_tag = t;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic g);
        wb_we = 1'b1; wb_wa = a; wb_wd = d; wb_wg = g;
    endtask

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            #1;
            if (out_valid) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    typedef struct {
        logic [AW-1:0] ra1, ra2;
        logic [31:0]   tag, exp1, exp2;
    } vec_t;

    vec_t vecs [5];
    bit   ok;
    logic [31:0] h1, h2, ht;

    initial begin
        vecs[0] = '{6'd5,  6'd6,  32'hA000_0001, 32'h0000_0011, 32'h0000_0022};
        vecs[1] = '{6'd0,  6'd5,  32'hA000_0002, 32'h0000_0000, 32'h0000_0011};
        vecs[2] = '{6'd31, 6'd63, 32'hA000_0003, 32'hDEAD_BEEF, 32'h6363_6363};
        vecs[3] = '{6'd6,  6'd6,  32'hA000_0004, 32'h0000_0022, 32'h0000_0022};
        vecs[4] = '{6'd0,  6'd0,  32'hA000_0005, 32'h0000_0000, 32'h0000_0000};

        rstn = 1'b0; idle(); in_ra1 = '0; in_ra2 = '0; in_tag = '0;
        wb_wa = '0; wb_wd = '0; wb_wg = 1'b0;
        for (int i = 0; i < 64; i++) begin arch_d[i] = '0; arch_g[i] = 1'b0; end
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_rf_ra1",    {26'd0, rf_ra1},    32'd0);
        chk("rst_out_tag",   out_tag,            32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Preload the register set through the write port.
        for (int i = 0; i < 64; i++) begin
            wr(i[5:0], 32'h0101_0101 * i, 1'b0);
            if (i == 0)  wr(6'd0,  32'hFFFF_FFFF, 1'b1);
            if (i == 5)  wr(6'd5,  32'h0000_0011, 1'b0);
            if (i == 6)  wr(6'd6,  32'h0000_0022, 1'b0);
            if (i == 31) wr(6'd31, 32'hDEAD_BEEF, 1'b0);
            if (i == 63) wr(6'd63, 32'h6363_6363, 1'b0);
            tick();
        end
        idle(); tick();

        // Table: fixed 2-cycle latency with immediate acceptance.
        for (int v = 0; v < 5; v++) begin
            issue(vecs[v].ra1, vecs[v].ra2, vecs[v].tag); tick();
            idle(); tick();
            #1;
            chk("vec_valid", {31'd0, out_valid}, 32'd1);
            chk("vec_op1", out_op1, vecs[v].exp1);
            chk("vec_op2", out_op2, vecs[v].exp2);
            chk("vec_tag", out_tag, vecs[v].tag);
            tick();
        end

        // Write and first read of x5 in the same cycle: bypass must win.
        issue(6'd5, 6'd6, 32'hB0B0_0001); wr(6'd5, 32'h0000_00AB, 1'b0); tick();
        idle(); tick();
        #1;
        chk("byp_valid", {31'd0, out_valid}, 32'd1);
        chk("byp_op1", out_op1, 32'h0000_00AB);
        tick();

        // Grubby x7 stalls until a clean write arrives.
        wr(6'd7, 32'h0000_0070, 1'b1); tick();
        idle(); issue(6'd7, 6'd0, 32'hC0C0_0007); tick();
        idle(); out_ready = 1'b0; tick(); tick(); tick();
        #1;
        chk("grubby_hold_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1; wr(6'd7, 32'h0000_0007, 1'b0); tick();
        idle();
        wait_valid(4, ok);
        chk("grubby_timeout", {31'd0, ok}, 32'd1);
        chk("grubby_op1", out_op1, 32'h0000_0007);
        tick();

        // x0 with both BRAM and write port carrying all-ones grubby data.
        issue(6'd0, 6'd5, 32'hD0D0_0000); wr(6'd0, 32'hFFFF_FFFF, 1'b1); tick();
        idle(); tick();
        #1;
        chk("x0_valid", {31'd0, out_valid}, 32'd1);
        chk("x0_op1", out_op1, 32'd0);
        tick();

        // Back-pressure: operands and tag stable for three cycles.
        issue(6'd6, 6'd31, 32'hE0E0_0006); out_ready = 1'b0; tick();
        in_valid = 1'b0; tick();
        #1; h1 = 32'h0000_0022; h2 = 32'hDEAD_BEEF; ht = 32'hE0E0_0006;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_op1", out_op1, h1);
            chk("stall_op2", out_op2, h2);
            chk("stall_tag", out_tag, ht);
            tick();
        end
        out_ready = 1'b1; tick();

        // Flush while waiting on a grubby operand.
        wr(6'd7, 32'h0000_0777, 1'b1); tick();
        idle(); issue(6'd7, 6'd7, 32'hF0F0_0007); tick();
        idle(); tick(); tick(); tick();
        flush = 1'b1; tick();
        flush = 1'b0;
        #1;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        wr(6'd7, 32'h0000_0007, 1'b0); tick();
        idle();

        // Random traffic against the reference model.
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 1) == 0);
            in_ra1    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
            in_ra2    = 6'($urandom_range(0, 7));
            in_tag    = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            wb_we     = ($urandom_range(0, 9) < 4);
            wb_wa     = 6'($urandom_range(0, 7));
            wb_wd     = $urandom;
            wb_wg     = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        idle(); repeat (4) tick();

        // Reset in the middle of an operation discards the entry.
        issue(6'd5, 6'd6, 32'h1234_5678); tick();
        idle(); tick();
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_rf_ra1", {26'd0, rf_ra1}, 32'd0);
        chk("mid_rst_tag", out_tag, 32'd0);
        m_held = 1'b0; m_ra1 = '0; m_ra2 = '0; m_tag = '0; m_stall = '0; m_cprev = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
